// File: rtl/centroid_tracker_if.sv
// Result bus of the centroid tracker: one frame's centroid, count and
// bounding box, held under a valid/ready handshake.
interface centroid_tracker_if #(
   parameter int XW    = 8,
   parameter int YW    = 7,
   parameter int CNT_W = 15
) ();
   logic             result_valid;
   logic             result_ready;
   logic [XW-1:0]    target_x;
   logic [YW-1:0]    target_y;
   logic             target_valid;
   logic [CNT_W-1:0] pixel_count;
   logic [XW-1:0]    box_x_min;
   logic [XW-1:0]    box_x_max;
   logic [YW-1:0]    box_y_min;
   logic [YW-1:0]    box_y_max;

   // producer side (tracker)
   modport master (
      input  result_ready,
      output result_valid, target_x, target_y, target_valid, pixel_count,
             box_x_min, box_x_max, box_y_min, box_y_max
   );

   // consumer side (overlay / tracking logic)
   modport slave (
      output result_ready,
      input  result_valid, target_x, target_y, target_valid, pixel_count,
             box_x_min, box_x_max, box_y_min, box_y_max
   );
endinterface

// File: rtl/centroid_tracker.sv
// Frame-level motion centroid tracker. Accumulates coordinate sums, count and
// bounding box of motion pixels inside a latched ROI; at frame_end the totals
// are snapshotted and divided by a fixed-latency restoring divider while the
// next frame accumulates. The y dividend shares the x-sized divider, so YW is
// expected to be no wider than XW.
module centroid_tracker #(
   parameter int IMG_W = 160,
   parameter int IMG_H = 120,
   parameter int XW    = 8,
   parameter int YW    = 7,
   parameter int CNT_W = 15,
   parameter int ROUND = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic             pixel_valid,
   input  logic             motion_pixel,
   input  logic [XW-1:0]    x_coord,
   input  logic [YW-1:0]    y_coord,
   input  logic [XW-1:0]    roi_x_min,
   input  logic [XW-1:0]    roi_x_max,
   input  logic [YW-1:0]    roi_y_min,
   input  logic [YW-1:0]    roi_y_max,
   input  logic [CNT_W-1:0] min_pixel_count,
   centroid_tracker_if.master res,
   output logic             busy,
   output logic             frame_dropped
);

   localparam int SXW     = XW + CNT_W;
   localparam int SYW     = YW + CNT_W;
   localparam int QW      = XW + CNT_W;
   localparam int DIV_CYC = QW;
   localparam int CW      = $clog2(DIV_CYC + 1);

   localparam logic [XW:0]   IMG_W_L = (XW+1)'(IMG_W);
   localparam logic [YW:0]   IMG_H_L = (YW+1)'(IMG_H);
   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

   // ---------------- accumulation ----------------
   logic [XW-1:0]    rx0_q, rx1_q;
   logic [YW-1:0]    ry0_q, ry1_q;
   logic [XW-1:0]    rx0_e, rx1_e;
   logic [YW-1:0]    ry0_e, ry1_e;
   logic [SXW-1:0]   sx_q, sx_d;
   logic [SYW-1:0]   sy_q, sy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XW-1:0]    bx0_q, bx0_d, bx1_q, bx1_d;
   logic [YW-1:0]    by0_q, by0_d, by1_q, by1_d;
   logic             hit;

   // A pixel arriving with frame_start belongs to the new frame, so it is
   // qualified against the ROI being latched, not the old one.
   always_comb begin
      rx0_e = frame_start ? roi_x_min : rx0_q;
      rx1_e = frame_start ? roi_x_max : rx1_q;
      ry0_e = frame_start ? roi_y_min : ry0_q;
      ry1_e = frame_start ? roi_y_max : ry1_q;
      hit   = pixel_valid && motion_pixel &&
              (x_coord >= rx0_e) && (x_coord <= rx1_e) &&
              (y_coord >= ry0_e) && (y_coord <= ry1_e) &&
              ({1'b0, x_coord} < IMG_W_L) && ({1'b0, y_coord} < IMG_H_L);
   end

   // Next accumulator state: clear on frame_start, then fold in a hit.
   always_comb begin
      sx_d  = frame_start ? '0 : sx_q;
      sy_d  = frame_start ? '0 : sy_q;
      cnt_d = frame_start ? '0 : cnt_q;
      bx0_d = frame_start ? '1 : bx0_q;
      bx1_d = frame_start ? '0 : bx1_q;
      by0_d = frame_start ? '1 : by0_q;
      by1_d = frame_start ? '0 : by1_q;
      if (hit) begin
         sx_d  = sx_d + SXW'(x_coord);
         sy_d  = sy_d + SYW'(y_coord);
         cnt_d = cnt_d + 1'b1;
         if (x_coord < bx0_d) bx0_d = x_coord;
         if (x_coord > bx1_d) bx1_d = x_coord;
         if (y_coord < by0_d) by0_d = y_coord;
         if (y_coord > by1_d) by1_d = y_coord;
      end
   end

   // Accumulator and ROI registers; ROI defaults to the full image.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx0_q <= '0;
         rx1_q <= X_LAST;
         ry0_q <= '0;
         ry1_q <= Y_LAST;
         sx_q  <= '0;
         sy_q  <= '0;
         cnt_q <= '0;
         bx0_q <= '1;
         bx1_q <= '0;
         by0_q <= '1;
         by1_q <= '0;
      end else begin
         if (frame_start) begin
            rx0_q <= roi_x_min;
            rx1_q <= roi_x_max;
            ry0_q <= roi_y_min;
            ry1_q <= roi_y_max;
         end
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         cnt_q <= cnt_d;
         bx0_q <= bx0_d;
         bx1_q <= bx1_d;
         by0_q <= by0_d;
         by1_q <= by1_d;
      end
   end

   // ---------------- snapshot / divider / result ----------------
   state_t           state_q;
   logic [SXW-1:0]   ssx_q;
   logic [SYW-1:0]   ssy_q;
   logic [CNT_W-1:0] scnt_q, sthr_q;
   logic [XW-1:0]    sbx0_q, sbx1_q;
   logic [YW-1:0]    sby0_q, sby1_q;
   logic [QW-1:0]    qx_q, qy_q;
   logic [CNT_W-1:0] rx_q, ry_q, dvs_q;
   logic [CW-1:0]    cyc_q;
   logic             rv_q, tv_q, busy_q, drop_q;
   logic [XW-1:0]    tx_q, obx0_q, obx1_q;
   logic [YW-1:0]    ty_q, oby0_q, oby1_q;
   logic [CNT_W-1:0] pc_q;

   logic             fe_acc;
   logic [CNT_W-1:0] dvs_ld, half_ld;
   logic [QW-1:0]    dx_ld, dy_ld;
   logic [CNT_W+QW-1:0] stx, sty;

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits. The remainder stays below the divisor.
   function automatic logic [CNT_W+QW-1:0] div_step(
      input logic [CNT_W-1:0] r,
      input logic [QW-1:0]    q,
      input logic [CNT_W-1:0] d
   );
      logic [CNT_W:0] rs;
      logic [QW-1:0]  qn;
      rs = {r, q[QW-1]};
      qn = {q[QW-2:0], 1'b0};
      if (rs >= {1'b0, d}) begin
         rs    = rs - {1'b0, d};
         qn[0] = 1'b1;
      end
      return {rs[CNT_W-1:0], qn};
   endfunction

   // Divider operands and next step; an empty frame divides by one.
   always_comb begin
      fe_acc  = frame_end && (state_q == IDLE || state_q == DONE);
      dvs_ld  = (scnt_q == '0) ? CNT_W'(1) : scnt_q;
      half_ld = (ROUND != 0) ? (dvs_ld >> 1) : '0;
      dx_ld   = QW'(ssx_q) + QW'(half_ld);
      dy_ld   = QW'(ssy_q) + QW'(half_ld);
      stx     = div_step(rx_q, qx_q, dvs_q);
      sty     = div_step(ry_q, qy_q, dvs_q);
   end

   // Control FSM with registered outputs: snapshot, divide, publish, handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ssx_q   <= '0;
         ssy_q   <= '0;
         scnt_q  <= '0;
         sthr_q  <= '0;
         sbx0_q  <= '0;
         sbx1_q  <= '0;
         sby0_q  <= '0;
         sby1_q  <= '0;
         qx_q    <= '0;
         qy_q    <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         dvs_q   <= '0;
         cyc_q   <= '0;
         rv_q    <= 1'b0;
         tv_q    <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
         tx_q    <= '0;
         ty_q    <= '0;
         pc_q    <= '0;
         obx0_q  <= '0;
         obx1_q  <= '0;
         oby0_q  <= '0;
         oby1_q  <= '0;
      end else begin
         drop_q <= 1'b0;
         if (rv_q && res.result_ready) rv_q <= 1'b0;
         // The snapshot includes a pixel arriving together with frame_end.
         if (fe_acc) begin
            ssx_q  <= sx_d;
            ssy_q  <= sy_d;
            scnt_q <= cnt_d;
            sthr_q <= min_pixel_count;
            sbx0_q <= bx0_d;
            sbx1_q <= bx1_d;
            sby0_q <= by0_d;
            sby1_q <= by1_d;
         end
         if (frame_end && !fe_acc) drop_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (frame_end) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               qx_q    <= dx_ld;
               qy_q    <= dy_ld;
               rx_q    <= '0;
               ry_q    <= '0;
               dvs_q   <= dvs_ld;
               cyc_q   <= '0;
               state_q <= DIV;
            end
            DIV: begin
               {rx_q, qx_q} <= stx;
               {ry_q, qy_q} <= sty;
               cyc_q        <= cyc_q + 1'b1;
               if (cyc_q == CW'(DIV_CYC - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               tx_q   <= qx_q[XW-1:0];
               ty_q   <= qy_q[YW-1:0];
               pc_q   <= scnt_q;
               tv_q   <= (scnt_q != '0) && (scnt_q >= sthr_q);
               obx0_q <= (scnt_q == '0) ? '0 : sbx0_q;
               obx1_q <= (scnt_q == '0) ? '0 : sbx1_q;
               oby0_q <= (scnt_q == '0) ? '0 : sby0_q;
               oby1_q <= (scnt_q == '0) ? '0 : sby1_q;
               rv_q   <= 1'b1;
               if (rv_q && !res.result_ready) drop_q <= 1'b1;
               // A frame_end landing on DONE starts the next division directly.
               if (frame_end) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res.result_valid = rv_q;
   assign res.target_x     = tx_q;
   assign res.target_y     = ty_q;
   assign res.target_valid = tv_q;
   assign res.pixel_count  = pc_q;
   assign res.box_x_min    = obx0_q;
   assign res.box_x_max    = obx1_q;
   assign res.box_y_min    = oby0_q;
   assign res.box_y_max    = oby1_q;
   assign busy             = busy_q;
   assign frame_dropped    = drop_q;

endmodule

// File: doc/centroid_tracker.md
Name: centroid_tracker

Overview:
- Parametrised successor to the frame-level motion centroid logic.
- Accumulates the coordinate sums, pixel count and bounding box of motion pixels inside a programmable region of interest (ROI).
- At frame_end it snapshots the accumulators and runs a fixed-latency radix-2 restoring divider with optional round-to-nearest, while the next frame accumulates in parallel (double-buffered).
- Results are held on a valid/ready interface for the lock-on overlay and tracking logic.

Parameters:
- IMG_W, 160: active image width in pixels.
- IMG_H, 120: active image height in pixels.
- XW, 8: x coordinate width; must satisfy 2^XW >= IMG_W.
- YW, 7: y coordinate width; must satisfy 2^YW >= IMG_H.
- CNT_W, 15: pixel counter width; must satisfy 2^CNT_W > IMG_W*IMG_H.
- ROUND, 1: 1 = round-to-nearest quotient, 0 = floor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_start  in  1  pulse; clears accumulators and samples the ROI
- frame_end  in  1  pulse; closes the frame and starts the division
- pixel_valid  in  1  pixel qualifier
- motion_pixel  in  1  1 = motion at this pixel
- x_coord  in  XW  pixel x
- y_coord  in  YW  pixel y
- roi_x_min, roi_x_max  in  XW  inclusive ROI x bounds
- roi_y_min, roi_y_max  in  YW  inclusive ROI y bounds
- min_pixel_count  in  CNT_W  validity threshold, sampled at frame_end
- result_ready  in  1  consumer accepts the result
- result_valid  out  1  result held until accepted
- target_x  out  XW  centroid x
- target_y  out  YW  centroid y
- target_valid  out  1  pixel_count >= threshold and pixel_count > 0
- pixel_count  out  CNT_W  motion pixels counted in the ROI
- box_x_min, box_x_max  out  XW  bounding box x
- box_y_min, box_y_max  out  YW  bounding box y
- busy  out  1  divider running
- frame_dropped  out  1  one-cycle pulse when a result is lost

Behaviour:
- Reset (reset == 0 at a clk edge):
  - All outputs go to 0; accumulators clear; FSM goes to IDLE.
  - A division in flight is abandoned and no result_valid is produced.
- Accumulation:
  - A pixel counts when pixel_valid && motion_pixel && x in [roi_x_min, roi_x_max] && y in [roi_y_min, roi_y_max] && x < IMG_W && y < IMG_H.
  - The ROI is latched at frame_start; before the first frame_start it defaults to the full image.
  - Each counted pixel adds x to sum_x (XW+CNT_W bits) and y to sum_y (YW+CNT_W bits), increments the count, and updates the box min/max.
  - Box min registers reset to all-ones and max registers to 0 on every frame_start.
- Simultaneous events:
  - frame_start together with a pixel: accumulators clear and the pixel is counted into the new frame.
  - frame_end together with a pixel: the pixel belongs to the ending frame.
  - frame_start with no preceding frame_end: the partial frame is discarded silently.
  - frame_end without a prior frame_start: treated as a normal frame_end on whatever has accumulated.
- FSM states:
  - IDLE -> LOAD on frame_end.
  - LOAD (1 cycle): snapshot the sums, count, box and threshold; divisor = max(count, 1); if ROUND, dividend = sum + (divisor >> 1).
  - DIV: DIV_CYC = XW+CNT_W cycles; both quotients are computed in parallel, one bit per cycle, MSB first.
  - DONE (1 cycle): write the output registers, assert result_valid, return to IDLE.
  - busy = 1 in LOAD and DIV.
- Latency: result_valid rises exactly XW+CNT_W+2 cycles after the clk edge that samples frame_end (25 cycles with defaults).
- Quotient width: quotients are truncated to XW/YW bits; the true centroid is always < IMG_W/IMG_H.
- Zero count: division still runs; target_x = target_y = 0, target_valid = 0, box outputs = 0, result_valid still asserts.
- Below threshold: the centroid is still reported, but target_valid = 0.
- Handshake:
  - Outputs are stable while result_valid && !result_ready.
  - result_valid drops the cycle after the clk edge where result_valid && result_ready.
  - DONE while result_valid is still pending: outputs are overwritten, result_valid stays 1, frame_dropped pulses.
- frame_end while busy: that frame's snapshot is discarded, frame_dropped pulses, the running division is unaffected, and accumulators still clear at the next frame_start.

Test Plan:
- Default params, ROI = full image, 10x10 block x=20..29, y=30..39, min_pixel_count=50 -> after exactly 25 cycles: pixel_count=100, target_x=25, target_y=35, box 20/29/30/39, target_valid=1.
- Same block with ROUND=0 -> target_x=24, target_y=34.
- 7x7 block at x=0..6, y=0..6, threshold 50 -> pixel_count=49, target_x=3, target_y=3, target_valid=0, result_valid=1.
- Empty frame -> pixel_count=0, target_x=0, target_y=0, target_valid=0, box all 0, result_valid=1.
- ROI x=0..15 with blocks at x=5..9 and x=100..109 (5 rows each, y=10..14) -> pixel_count=25, target_x=7, target_y=12.
- Concurrency and reset:
  - result_ready=0 across two frames -> second DONE pulses frame_dropped and shows the second frame's values.
  - frame_end 5 cycles after the previous frame_end -> frame_dropped pulses.
  - reset low mid-DIV -> all outputs 0, no result_valid.
